// File: rtl/pwm_multi_if.sv
// Register-write bus for pwm_multi: one-cycle strobe, address and data.
// Addresses 0..CHANNELS-1 select duty registers; CHANNELS selects the period.
interface pwm_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int AW = $clog2(CHANNELS + 1);

    logic          bus_write;
    logic [AW-1:0] bus_address;
    logic [WIDTH-1:0] bus_wdata;

    modport master (
        output bus_write,
        output bus_address,
        output bus_wdata
    );

    modport slave (
        input bus_write,
        input bus_address,
        input bus_wdata
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter,
// double-buffered duty/period registers and registered outputs.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] pwm_invert,
    pwm_multi_if.slave          bus,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam int AW = $clog2(CHANNELS + 1);
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    logic [15:0]         presc_reg;
    logic [15:0]         presc_next;
    logic                tick;
    logic [WIDTH-1:0]    counter_reg;
    logic [WIDTH-1:0]    counter_next;
    dir_t                dir_reg;
    dir_t                dir_next;
    logic                wrap;
    logic                run_reg;
    logic                zero_event_reg;
    logic                load_active;
    logic [WIDTH-1:0]    shadow_period_reg;
    logic [WIDTH-1:0]    active_period_reg;
    logic                active_mode_reg;
    logic [CHANNELS-1:0] raw_level;
    logic [CHANNELS-1:0] pwm_out_reg;
    logic                period_start_reg;

    always_comb begin
        tick       = enable && (presc_reg == PRESCALE_LAST);
        presc_next = (!enable || tick) ? 16'd0 : presc_reg + 16'd1;
    end

    // Disabled: active copies track shadow so a fresh start uses the latest values.
    assign load_active = !enable || wrap;

    always_comb begin
        counter_next = counter_reg;
        dir_next     = dir_reg;
        wrap         = 1'b0;
        if (!enable) begin
            counter_next = '0;
            dir_next     = UP;
        end else if (tick) begin
            if (!run_reg) begin
                // First tick after enable counts as entering 0.
                counter_next = '0;
                dir_next     = UP;
                wrap         = 1'b1;
            end else if (!active_mode_reg) begin
                dir_next = UP;
                if (counter_reg >= active_period_reg) begin
                    counter_next = '0;
                    wrap         = 1'b1;
                end else begin
                    counter_next = counter_reg + 1'b1;
                end
            end else begin
                case (dir_reg)
                    UP: begin
                        if (counter_reg < active_period_reg) begin
                            counter_next = counter_reg + 1'b1;
                        end else if (active_period_reg <= WIDTH'(1)) begin
                            counter_next = '0;
                            wrap         = 1'b1;
                        end else begin
                            counter_next = active_period_reg - 1'b1;
                            dir_next     = DOWN;
                        end
                    end
                    default: begin
                        if (counter_reg <= WIDTH'(1)) begin
                            counter_next = '0;
                            dir_next     = UP;
                            wrap         = 1'b1;
                        end else begin
                            counter_next = counter_reg - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg      <= '0;
            counter_reg    <= '0;
            dir_reg        <= UP;
            run_reg        <= 1'b0;
            zero_event_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            counter_reg    <= counter_next;
            dir_reg        <= dir_next;
            run_reg        <= enable && (run_reg || tick);
            zero_event_reg <= wrap;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_period_reg <= '1;
            active_period_reg <= '1;
            active_mode_reg   <= 1'b0;
        end else begin
            if (load_active) begin
                active_period_reg <= shadow_period_reg;
                active_mode_reg   <= center_mode;
            end
            if (bus.bus_write && (bus.bus_address == AW'(CHANNELS))) begin
                shadow_period_reg <= bus.bus_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [WIDTH-1:0] shadow_duty_reg;
        logic [WIDTH-1:0] active_duty_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow_duty_reg <= '0;
                active_duty_reg <= '0;
            end else begin
                if (load_active) begin
                    active_duty_reg <= shadow_duty_reg;
                end
                if (bus.bus_write && (bus.bus_address == AW'(gi))) begin
                    shadow_duty_reg <= bus.bus_wdata;
                end
            end
        end

        assign raw_level[gi] = (counter_reg < active_duty_reg);
    end

    // Outputs reflect the counter value one clock after it was updated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out_reg      <= '0;
            period_start_reg <= 1'b0;
        end else begin
            pwm_out_reg      <= (enable && run_reg) ? (raw_level ^ pwm_invert) : pwm_invert;
            period_start_reg <= enable && zero_event_reg;
        end
    end

    assign pwm_out      = pwm_out_reg;
    assign period_start = period_start_reg;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed and randomized checks of pwm_multi (4 channels, 8-bit, prescale 1)
// against a phase-based reference model of the counter and register buffering.
module tb_pwm_multi;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       center_mode = 1'b0;
    logic [3:0] pwm_invert = 4'b0000;
    logic [3:0] pwm_out;
    logic       period_start;

    pwm_multi_if #(.CHANNELS(4), .WIDTH(8)) bus_if ();

    pwm_multi #(.CHANNELS(4), .WIDTH(8), .PRESCALE(1)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .center_mode(center_mode),
        .pwm_invert(pwm_invert),
        .bus(bus_if),
        .pwm_out(pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the period, shadow and active sets.
    int   s_duty[4];
    int   a_duty[4];
    int   s_period, a_period;
    bit   a_mode;
    bit   started, entered;
    int   pos, m_cnt;
    logic [3:0] e_pwm;
    logic       e_ps;

    int hi[4];
    int starts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            s_duty[c] = 0;
            a_duty[c] = 0;
        end
        s_period = 255;
        a_period = 255;
        a_mode   = 1'b0;
        started  = 1'b0;
        entered  = 1'b0;
        pos      = 0;
        m_cnt    = 0;
        e_pwm    = 4'b0000;
        e_ps     = 1'b0;
    endtask

    task automatic load_active();
        for (int c = 0; c < 4; c++) a_duty[c] = s_duty[c];
        a_period = s_period;
        a_mode   = center_mode;
    endtask

    task automatic model_step();
        int len;
        if (!enable) begin
            e_pwm = pwm_invert;
            e_ps  = 1'b0;
        end else begin
            for (int c = 0; c < 4; c++)
                e_pwm[c] = started ? ((m_cnt < a_duty[c]) ^ pwm_invert[c]) : pwm_invert[c];
            e_ps = entered;
        end
        entered = 1'b0;
        if (!enable) begin
            started = 1'b0;
            pos     = 0;
            load_active();
        end else if (!started) begin
            started = 1'b1;
            pos     = 0;
            entered = 1'b1;
            load_active();
        end else begin
            len = a_mode ? 2 * a_period : a_period + 1;
            if (len == 0) len = 1;
            pos = (pos + 1) % len;
            if (pos == 0) begin
                entered = 1'b1;
                load_active();
            end
        end
        m_cnt = (a_mode && pos > a_period) ? 2 * a_period - pos : pos;
        if (bus_if.bus_write) begin
            if (bus_if.bus_address < 4) s_duty[bus_if.bus_address] = bus_if.bus_wdata;
            else if (bus_if.bus_address == 4) s_period = bus_if.bus_wdata;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("pwm_out", pwm_out, e_pwm);
        chk("period_start", period_start, e_ps);
    endtask

    task automatic wr(input int addr, input int data);
        bus_if.bus_write   = 1'b1;
        bus_if.bus_address = 3'(addr);
        bus_if.bus_wdata   = 8'(data);
        cycle();
        bus_if.bus_write   = 1'b0;
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        starts = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
            starts += int'(period_start);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = '0;
        bus_if.bus_wdata   = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pwm", pwm_out, 0);
        chk("reset_ps", period_start, 0);
        reset = 1'b0;
        repeat (3) cycle();

        // Edge-aligned: period 9, ch0 duty 3
        wr(4, 9);
        wr(0, 3);
        enable = 1'b1;
        cycle();
        measure(20);
        chk("edge_ch0_high", hi[0], 6);
        chk("edge_starts", starts, 2);

        // Double buffering: duty 6 written while counter is 2
        repeat (2) cycle();
        wr(0, 6);
        measure(7);
        chk("dbuf_tail_high", hi[0], 0);
        chk("dbuf_tail_starts", starts, 0);
        measure(10);
        chk("dbuf_next_high", hi[0], 6);
        chk("dbuf_next_starts", starts, 1);

        // Polarity on ch1, then disable
        pwm_invert = 4'b0010;
        wr(1, 3);
        repeat (9) cycle();
        measure(20);
        chk("inv_ch1_high", hi[1], 14);
        chk("inv_ch0_high", hi[0], 12);
        chk("inv_starts", starts, 2);
        enable = 1'b0;
        cycle();
        chk("dis_pwm", pwm_out, 4'b0010);
        measure(5);
        chk("dis_starts", starts, 0);
        chk("dis_ch1_high", hi[1], 5);

        // Extremes: duty 0 and duty above period
        pwm_invert = 4'b0000;
        wr(1, 0);
        wr(2, 255);
        enable = 1'b1;
        cycle();
        measure(20);
        chk("ext_ch1_zero", hi[1], 0);
        chk("ext_ch2_full", hi[2], 20);
        chk("ext_ch0_high", hi[0], 12);

        // Period 0
        enable = 1'b0;
        wr(4, 0);
        wr(0, 1);
        enable = 1'b1;
        cycle();
        measure(10);
        chk("p0_ch0_high", hi[0], 10);
        chk("p0_starts", starts, 10);

        // Center-aligned, period 4
        enable = 1'b0;
        wr(4, 4);
        wr(0, 2);
        wr(1, 4);
        wr(3, 1);
        center_mode = 1'b1;
        enable = 1'b1;
        cycle();
        measure(16);
        chk("ctr_ch0_high", hi[0], 6);
        chk("ctr_ch1_high", hi[1], 14);
        chk("ctr_ch3_high", hi[3], 2);
        chk("ctr_starts", starts, 2);

        // Asynchronous reset at counter 5
        enable = 1'b0;
        center_mode = 1'b0;
        wr(4, 9);
        wr(0, 3);
        pwm_invert = 4'b1111;
        enable = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("pre_rst_pwm", pwm_out, 4'b1011);
        reset = 1'b1;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_ps", period_start, 0);
        model_reset();
        @(posedge clk);
        #1;
        pwm_invert = 4'b0000;
        reset = 1'b0;
        cycle();
        measure(512);
        chk("post_rst_high", hi[0] + hi[1] + hi[2] + hi[3], 0);
        chk("post_rst_starts", starts, 2);

        // Randomized traffic against the model
        for (int round = 0; round < 8; round++) begin
            enable = 1'b0;
            cycle();
            wr(4, int'($urandom_range(0, 12)));
            for (int c = 0; c < 4; c++) wr(c, int'($urandom_range(0, 15)));
            pwm_invert  = 4'($urandom);
            center_mode = 1'($urandom);
            enable = 1'b1;
            for (int k = 0; k < 80; k++) begin
                r = int'($urandom_range(0, 15));
                if (r <= 1) begin
                    wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
                end else if (r == 2) begin
                    center_mode = ~center_mode;
                    cycle();
                end else if (r == 3) begin
                    enable = 1'b0;
                    cycle();
                    enable = 1'b1;
                end else begin
                    cycle();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs, 1..16.
REQ-002 Parameter WIDTH, default 8: bit width of counter, period and duty values, 2..16.
REQ-003 Parameter PRESCALE, default 1: clk cycles per counter tick, 1..65535.
REQ-004 Port clk, input, 1: single clock; all logic is in this domain.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port enable, input, 1: 1 = run counter; 0 = stop, hold counter at 0, force outputs to their inactive level.
REQ-007 Port center_mode, input, 1: 0 = edge-aligned counting; 1 = center-aligned counting.
REQ-008 Port pwm_invert, input, CHANNELS: per-channel output polarity; 1 = inverted.
REQ-009 Port bus_write, input, 1: one-cycle write strobe.
REQ-010 Port bus_address, input, $clog2(CHANNELS+1): 0..CHANNELS-1 selects a channel duty register; CHANNELS selects the period register.
REQ-011 Port bus_wdata, input, WIDTH: write data.
REQ-012 Port pwm_out, output, CHANNELS: registered PWM outputs.
REQ-013 Port period_start, output, 1: one-cycle pulse when the counter enters 0.

Function
REQ-014 Each register (duty per channel, period) SHALL be double-buffered as a shadow copy (bus-written) and an active copy (used for comparison).
REQ-015 A bus_write to an out-of-range address SHALL be ignored.
REQ-016 Prescaler: counts clk cycles; SHALL issue one tick every PRESCALE cycles while enable=1, and SHALL clear to 0 while enable=0.
REQ-017 Edge-aligned mode: counter SHALL go 0,1,...,period then back to 0, one step per tick; period length = period+1 ticks.
REQ-018 Center-aligned mode: state UP counts 0..period; at period it enters DOWN; DOWN counts period-1..1; after 1 the counter goes to 0 in UP; period length = 2*period ticks.
REQ-019 period=0 in either mode: counter SHALL stay at 0, and period_start SHALL pulse every tick.
REQ-020 Shadow-to-active transfer SHALL happen, for all registers at once, on the tick on which the counter enters 0.
REQ-021 Write and transfer in the same cycle: active SHALL take the old shadow value; the new value SHALL stay in shadow until the next transfer.
REQ-022 While enable=0, active registers SHALL follow shadow every cycle.
REQ-023 Raw channel level = (counter < active_duty), as an unsigned WIDTH-bit compare; pwm_out[i] = raw XOR pwm_invert[i]; duty=0 gives constant raw low; duty>period gives constant raw high.
REQ-024 pwm_out and period_start SHALL be registered, with a latency of one clk after the counter update they reflect.
REQ-025 While enable=0, pwm_out[i] SHALL equal pwm_invert[i], and period_start SHALL be 0.
REQ-026 On enable rising, counter SHALL start from 0 in UP, and period_start SHALL pulse on the first tick.
REQ-027 A change of center_mode SHALL take effect at the next counter entry to 0; it is sampled into the active set together with the other registers.

Reset
REQ-028 On reset, the following SHALL clear asynchronously:
- counter, prescaler and direction → 0 / UP;
- shadow and active duty → 0;
- shadow and active period → 2**WIDTH-1;
- active mode → edge;
- pwm_out → 0;
- period_start → 0.
REQ-029 After reset release, operation SHALL resume on the first clk edge with reset low.
REQ-030 Reset asserted mid-period SHALL abort the period with no glitch beyond the asynchronous clear.

Verification (CHANNELS=4, WIDTH=8, PRESCALE=1)
REQ-031 Edge PWM: write period=9 and ch0 duty=3 with enable=0, then enable=1 -> ch0 high 3 clk, low 7 clk, repeating; period_start every 10 clk.
REQ-032 Double buffering: with the scenario of REQ-031 running, write ch0 duty=6 at counter=2 -> current period keeps 3 high; the next period (after period_start) shows 6 high / 4 low.
REQ-033 Extremes: ch1 duty=0 -> pwm_out[1] constant 0; ch2 duty=255 with period=9 -> pwm_out[2] constant 1; period=0 with duty=1 -> constant 1, period_start every clk.
REQ-034 Center mode: period=4, ch0 duty=2, center_mode=1 -> counter sequence 0,1,2,3,4,3,2,1; ch0 high for 3 of 8 clk (counter 0,1 and down-count 1); period_start every 8 clk.
REQ-035 Polarity and enable: pwm_invert=4'b0010 -> ch1 is the complement of REQ-031 behaviour; enable=0 -> pwm_out=4'b0010 within 1 clk, and period_start stays 0.
REQ-036 Async reset mid-run at counter=5 -> all outputs 0 immediately, before the next clk edge; after release, period=255 and duty=0 are read back via behaviour (all channels low, period_start every 256 clk).
